// File: rtl/sr_ff_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : sr_ff_driver_if
// Brief    : Valid/ready bit-stream channel feeding the sr_ff driver.
// Revision : 1.0 - initial release
// ============================================================================
interface sr_ff_driver_if;
   logic in_bit;
   logic in_valid;
   logic in_ready;

   modport master (output in_bit, output in_valid, input in_ready);
   modport slave  (input in_bit, input in_valid, output in_ready);
endinterface
`default_nettype wire

// File: rtl/sr_ff_driver.sv
`default_nettype none
// ============================================================================
// Module   : sr_ff_driver
// Brief    : Converts target Q bits into legal S/R excitation for an sr_ff,
//            checks Q feedback and keeps saturating transfer/error counts.
// Revision : 1.0 - initial release
// ============================================================================
module sr_ff_driver #(
   parameter int CNT_W       = 8,
   parameter bit STOP_ON_ERR = 1'b0
) (
   input  wire logic             clk,
   input  wire logic             rst,
   sr_ff_driver_if.slave         stream,
   input  wire logic             clr_cnt,
   input  wire logic             q_fb,
   output logic                  s_out,
   output logic                  r_out,
   output logic                  q_model,
   output logic                  done,
   output logic                  mismatch,
   output logic                  err_flag,
   output logic [CNT_W-1:0]      tx_count,
   output logic [CNT_W-1:0]      err_count
);

   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_IDLE  = 3'd1,
      ST_DRIVE = 3'd2,
      ST_CHECK = 3'd3,
      ST_HALT  = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] c_cnt_max = '1;
   localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

   state_t           r_state;
   logic             r_target;
   logic             r_s;
   logic             r_r;
   logic             r_q_model;
   logic             r_done;
   logic             r_mismatch;
   logic             r_err_flag;
   logic [CNT_W-1:0] r_tx_count;
   logic [CNT_W-1:0] r_err_count;
   logic             w_mis;

   assign w_mis           = q_fb ^ r_target;
   assign stream.in_ready = (r_state == ST_IDLE);

   assign s_out     = r_s;
   assign r_out     = r_r;
   assign q_model   = r_q_model;
   assign done      = r_done;
   assign mismatch  = r_mismatch;
   assign err_flag  = r_err_flag;
   assign tx_count  = r_tx_count;
   assign err_count = r_err_count;

   // R held high in reset and INIT so the driven FF starts from a known Q=0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_INIT;
         r_target    <= 1'b0;
         r_s         <= 1'b0;
         r_r         <= 1'b1;
         r_q_model   <= 1'b0;
         r_done      <= 1'b0;
         r_mismatch  <= 1'b0;
         r_err_flag  <= 1'b0;
         r_tx_count  <= '0;
         r_err_count <= '0;
      end else begin
         r_done     <= 1'b0;
         r_mismatch <= 1'b0;
         r_s        <= 1'b0;
         r_r        <= 1'b0;

         case (r_state)
            ST_INIT: begin
               r_state <= ST_IDLE;
            end
            ST_IDLE: begin
               if (stream.in_valid) begin
                  r_target <= stream.in_bit;
                  r_s      <= stream.in_bit & ~r_q_model;
                  r_r      <= ~stream.in_bit & r_q_model;
                  r_state  <= ST_DRIVE;
               end
            end
            ST_DRIVE: begin
               r_state <= ST_CHECK;
            end
            ST_CHECK: begin
               r_done     <= 1'b1;
               r_mismatch <= w_mis;
               r_q_model  <= q_fb;
               if (r_tx_count != c_cnt_max) begin
                  r_tx_count <= r_tx_count + c_cnt_one;
               end
               if (w_mis) begin
                  r_err_flag <= 1'b1;
                  if (r_err_count != c_cnt_max) begin
                     r_err_count <= r_err_count + c_cnt_one;
                  end
               end
               r_state <= (w_mis && STOP_ON_ERR) ? ST_HALT : ST_IDLE;
            end
            ST_HALT: begin
               if (clr_cnt) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_INIT;
            end
         endcase

         // Clear takes priority over any increment in the same cycle
         if (clr_cnt) begin
            r_tx_count  <= '0;
            r_err_count <= '0;
            r_err_flag  <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sr_ff_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_ff_driver
// Brief    : Directed bench for sr_ff_driver: three instances (default,
//            halt-on-error, 2-bit counters) each driving a behavioural sr_ff.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sr_ff_driver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst      [3];
   logic in_bit   [3];
   logic in_valid [3];
   logic clr      [3];
   logic fault    [3];
   logic in_ready [3];
   logic s        [3];
   logic r        [3];
   logic qm       [3];
   logic done     [3];
   logic mm       [3];
   logic errf     [3];
   logic ffq      [3];
   logic qfb      [3];
   logic [7:0] tx [3];
   logic [7:0] ec [3];
   logic [7:0] tx0, ec0, tx1, ec1;
   logic [1:0] tx2, ec2;

   int total = 0;
   int bad   = 0;

   sr_ff_driver_if if0();
   sr_ff_driver_if if1();
   sr_ff_driver_if if2();

   assign if0.in_bit = in_bit[0];  assign if0.in_valid = in_valid[0];  assign in_ready[0] = if0.in_ready;
   assign if1.in_bit = in_bit[1];  assign if1.in_valid = in_valid[1];  assign in_ready[1] = if1.in_ready;
   assign if2.in_bit = in_bit[2];  assign if2.in_valid = in_valid[2];  assign in_ready[2] = if2.in_ready;

   assign tx[0] = tx0;           assign ec[0] = ec0;
   assign tx[1] = tx1;           assign ec[1] = ec1;
   assign tx[2] = {6'd0, tx2};   assign ec[2] = {6'd0, ec2};

   assign qfb[0] = ffq[0] & ~fault[0];
   assign qfb[1] = ffq[1] & ~fault[1];
   assign qfb[2] = ffq[2] & ~fault[2];

   sr_ff_driver #(.CNT_W(8), .STOP_ON_ERR(1'b0)) dut0 (
      .clk(clk), .rst(rst[0]), .stream(if0.slave), .clr_cnt(clr[0]), .q_fb(qfb[0]),
      .s_out(s[0]), .r_out(r[0]), .q_model(qm[0]), .done(done[0]), .mismatch(mm[0]),
      .err_flag(errf[0]), .tx_count(tx0), .err_count(ec0));

   sr_ff_driver #(.CNT_W(8), .STOP_ON_ERR(1'b1)) dut1 (
      .clk(clk), .rst(rst[1]), .stream(if1.slave), .clr_cnt(clr[1]), .q_fb(qfb[1]),
      .s_out(s[1]), .r_out(r[1]), .q_model(qm[1]), .done(done[1]), .mismatch(mm[1]),
      .err_flag(errf[1]), .tx_count(tx1), .err_count(ec1));

   sr_ff_driver #(.CNT_W(2), .STOP_ON_ERR(1'b0)) dut2 (
      .clk(clk), .rst(rst[2]), .stream(if2.slave), .clr_cnt(clr[2]), .q_fb(qfb[2]),
      .s_out(s[2]), .r_out(r[2]), .q_model(qm[2]), .done(done[2]), .mismatch(mm[2]),
      .err_flag(errf[2]), .tx_count(tx2), .err_count(ec2));

   // Behavioural sr_ff instances driven by the DUT excitation
   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (s[k]) ffq[k] <= 1'b1;
         else if (r[k]) ffq[k] <= 1'b0;
      end
   end

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s dut%0d t=%0t got=%0d want=%0d", nm, k, $time, act, exp);
      end
   endtask

   // Transaction-level reference: per instance, a busy countdown after each accept,
   // its own copy of the FF, and the counters computed from the outcome rules.
   int  sat_max [3] = '{255, 255, 3};
   bit  stop_on [3] = '{1'b0, 1'b1, 1'b0};
   bit  m_init  [3];
   bit  m_halt  [3];
   int  m_busy  [3];
   bit  m_tgt   [3];
   bit  m_ff    [3];
   bit  e_s     [3];
   bit  e_r     [3];
   bit  e_qm    [3];
   bit  e_done  [3];
   bit  e_mm    [3];
   bit  e_err   [3];
   int  e_tx    [3];
   int  e_ec    [3];

   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         bit qp;
         qp = m_ff[k] & ~fault[k];
         if (rst[k] || e_r[k]) m_ff[k] = 1'b0;
         else if (e_s[k])      m_ff[k] = 1'b1;

         if (rst[k]) begin
            m_init[k] = 1'b1;  m_halt[k] = 1'b0;  m_busy[k] = 0;  m_tgt[k] = 1'b0;
            e_s[k] = 1'b0;  e_r[k] = 1'b1;  e_qm[k] = 1'b0;  e_done[k] = 1'b0;
            e_mm[k] = 1'b0; e_err[k] = 1'b0; e_tx[k] = 0;    e_ec[k] = 0;
         end else begin
            e_s[k] = 1'b0;  e_r[k] = 1'b0;  e_done[k] = 1'b0;  e_mm[k] = 1'b0;
            if (m_init[k]) begin
               m_init[k] = 1'b0;
            end else if (m_halt[k]) begin
               if (clr[k]) m_halt[k] = 1'b0;
            end else if (m_busy[k] == 0) begin
               if (in_valid[k]) begin
                  m_tgt[k]  = in_bit[k];
                  e_s[k]    = (in_bit[k] == 1'b1) && (e_qm[k] == 1'b0);
                  e_r[k]    = (in_bit[k] == 1'b0) && (e_qm[k] == 1'b1);
                  m_busy[k] = 2;
               end
            end else if (m_busy[k] == 2) begin
               m_busy[k] = 1;
            end else begin
               m_busy[k] = 0;
               e_done[k] = 1'b1;
               e_mm[k]   = (qp != m_tgt[k]);
               e_qm[k]   = qp;
               if (e_tx[k] < sat_max[k]) e_tx[k] = e_tx[k] + 1;
               if (e_mm[k]) begin
                  e_err[k] = 1'b1;
                  if (e_ec[k] < sat_max[k]) e_ec[k] = e_ec[k] + 1;
                  if (stop_on[k]) m_halt[k] = 1'b1;
               end
            end
            if (clr[k]) begin
               e_tx[k] = 0;  e_ec[k] = 0;  e_err[k] = 1'b0;
            end
         end
      end
   end

   always @(posedge clk) begin
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("s_and_r",   k, 32'(s[k] & r[k]), 32'd0);
         chk("in_ready",  k, 32'(in_ready[k]),
             32'(!rst[k] && !m_init[k] && !m_halt[k] && m_busy[k] == 0));
         chk("s_out",     k, 32'(s[k]),    32'(e_s[k]));
         chk("r_out",     k, 32'(r[k]),    32'(rst[k] ? 1'b1 : e_r[k]));
         chk("q_model",   k, 32'(qm[k]),   32'(e_qm[k]));
         chk("done",      k, 32'(done[k]), 32'(e_done[k]));
         chk("mismatch",  k, 32'(mm[k]),   32'(e_mm[k]));
         chk("err_flag",  k, 32'(errf[k]), 32'(e_err[k]));
         chk("tx_count",  k, 32'(tx[k]),   32'(e_tx[k]));
         chk("err_count", k, 32'(ec[k]),   32'(e_ec[k]));
      end
   end

   task automatic send(input int k, input bit b, input logic [1:0] exp_sr, input bit clr_at_check);
      int n;
      @(negedge clk);
      in_bit[k]   = b;
      in_valid[k] = 1'b1;
      n = 0;
      while (in_ready[k] !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         chk("ready_timeout", k, 32'(in_ready[k]), 32'd1);
         in_valid[k] = 1'b0;
         return;
      end
      @(posedge clk);
      #1 chk("sr_excite", k, 32'({s[k], r[k]}), 32'(exp_sr));
      @(negedge clk);
      in_valid[k] = 1'b0;
      @(posedge clk);
      if (clr_at_check) begin
         @(negedge clk);
         clr[k] = 1'b1;
      end
      @(posedge clk);
      #1 chk("done_lat", k, 32'(done[k]), 32'd1);
      if (clr_at_check) begin
         @(negedge clk);
         clr[k] = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < 3; k++) begin
         rst[k] = 1'b1;  in_bit[k] = 1'b0;  in_valid[k] = 1'b0;
         clr[k] = 1'b0;  fault[k]  = 1'b0;
      end

      // Reset and release
      repeat (3) @(negedge clk);
      chk("rst_r_out", 0, 32'(r[0]), 32'd1);
      chk("rst_ready", 0, 32'(in_ready[0]), 32'd0);
      for (int k = 0; k < 3; k++) rst[k] = 1'b0;
      #1 chk("init_r_out", 0, 32'(r[0]), 32'd1);
      @(posedge clk);
      #1 chk("idle_r_out", 0, 32'(r[0]), 32'd0);
      chk("idle_ready", 0, 32'(in_ready[0]), 32'd1);
      chk("idle_tx", 0, 32'(tx[0]), 32'd0);

      // Clean stream 1,1,0,0,1
      send(0, 1'b1, 2'b10, 1'b0);
      send(0, 1'b1, 2'b00, 1'b0);
      send(0, 1'b0, 2'b01, 1'b0);
      send(0, 1'b0, 2'b00, 1'b0);
      send(0, 1'b1, 2'b10, 1'b0);
      chk("stream_tx", 0, 32'(tx[0]), 32'd5);
      chk("stream_ec", 0, 32'(ec[0]), 32'd0);
      chk("stream_qm", 0, 32'(qm[0]), 32'd1);

      // Stuck-at-0 feedback while targeting 1, keep running
      send(0, 1'b0, 2'b01, 1'b0);
      @(negedge clk) fault[0] = 1'b1;
      send(0, 1'b1, 2'b10, 1'b0);
      chk("fault_mm", 0, 32'(mm[0]), 32'd1);
      chk("fault_ec", 0, 32'(ec[0]), 32'd1);
      chk("fault_flag", 0, 32'(errf[0]), 32'd1);
      chk("fault_qm", 0, 32'(qm[0]), 32'd0);
      @(negedge clk) fault[0] = 1'b0;
      send(0, 1'b1, 2'b10, 1'b0);
      chk("after_fault_tx", 0, 32'(tx[0]), 32'd8);

      // Halt on error, released by clr_cnt
      send(1, 1'b0, 2'b00, 1'b0);
      @(negedge clk) fault[1] = 1'b1;
      send(1, 1'b1, 2'b10, 1'b0);
      chk("halt_mm", 1, 32'(mm[1]), 32'd1);
      @(negedge clk) in_valid[1] = 1'b1;
      repeat (4) @(negedge clk);
      chk("halt_ready", 1, 32'(in_ready[1]), 32'd0);
      chk("halt_flag", 1, 32'(errf[1]), 32'd1);
      clr[1] = 1'b1;  in_valid[1] = 1'b0;  fault[1] = 1'b0;
      @(posedge clk);
      #1 chk("release_ready", 1, 32'(in_ready[1]), 32'd1);
      chk("release_tx", 1, 32'(tx[1]), 32'd0);
      chk("release_ec", 1, 32'(ec[1]), 32'd0);
      chk("release_flag", 1, 32'(errf[1]), 32'd0);
      @(negedge clk) clr[1] = 1'b0;

      // 2-bit counters: saturate, then clear coincident with a CHECK
      send(2, 1'b1, 2'b10, 1'b0);
      send(2, 1'b0, 2'b01, 1'b0);
      send(2, 1'b1, 2'b10, 1'b0);
      chk("sat3_tx", 2, 32'(tx[2]), 32'd3);
      send(2, 1'b0, 2'b01, 1'b0);
      chk("sat_hold_tx", 2, 32'(tx[2]), 32'd3);
      send(2, 1'b1, 2'b10, 1'b1);
      chk("clr_wins_tx", 2, 32'(tx[2]), 32'd0);

      // Reset during DRIVE aborts the transfer
      @(negedge clk);
      in_bit[2] = 1'b0;  in_valid[2] = 1'b1;
      @(posedge clk);
      #1 chk("abort_sr", 2, 32'({s[2], r[2]}), 32'b01);
      @(negedge clk);
      in_valid[2] = 1'b0;  rst[2] = 1'b1;
      #1 chk("abort_r_out", 2, 32'(r[2]), 32'd1);
      chk("abort_ready", 2, 32'(in_ready[2]), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 chk("abort_no_done", 2, 32'(done[2]), 32'd0);
      @(negedge clk) rst[2] = 1'b0;
      @(posedge clk);
      #1 chk("abort_idle", 2, 32'(in_ready[2]), 32'd1);
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
